// File: rtl/apb_global_pkg.sv
// Shared arbiter types and sizing helpers for the APB interconnect.
package apb_global_pkg;

    localparam int NO_OF_MASTERS = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Master-index width; a single master still needs a 1-bit index.
    function automatic int mid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_wrr_pick.sv
// Combinational winner selection: rotating search from ptr_i, or lowest index
// when fixed_prio_i is set. Produces a one-hot grant (zero when no request).
module apb_wrr_pick #(
    parameter int N     = 2,
    parameter int MID_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [MID_W-1:0] ptr_i,
    input  logic             fixed_prio_i,
    output logic [N-1:0]     grant_o
);

    logic             found;
    int               idx;
    logic [MID_W-1:0] sel;

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            idx = fixed_prio_i ? k : int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            sel = idx[MID_W-1:0];
            if (!found && req_i[sel]) begin
                grant_o[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_wrr_arbiter.sv
// Per-slave APB arbiter: weighted round-robin or fixed priority, one owner at a time.
// Optional ownership watchdog enabled by defining APB_ARB_WATCHDOG_EN.
module apb_wrr_arbiter #(
    parameter int  NO_OF_MASTERS  = apb_global_pkg::NO_OF_MASTERS,
    parameter int  WEIGHT_W       = 4,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int MID_W          = apb_global_pkg::mid_w(NO_OF_MASTERS)
) (
    input  logic                              pclk,
    input  logic                              preset_n,
    input  logic [NO_OF_MASTERS-1:0]          req_i,
    input  logic [NO_OF_MASTERS*WEIGHT_W-1:0] weight_i,
    input  logic                              fixed_prio_i,
    input  logic                              done_i,
    output logic [NO_OF_MASTERS-1:0]          grant_o,
    output logic [MID_W-1:0]                  owner_o,
    output logic                              busy_o,
    output logic                              timeout_o
);

    import apb_global_pkg::*;

    if (NO_OF_MASTERS < 1 || NO_OF_MASTERS > 16) begin : g_bad_masters
        $error("apb_wrr_arbiter: NO_OF_MASTERS must be 1..16");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_wrr_arbiter: TIMEOUT_CYCLES must be 2..65535");
    end

    arb_state_e               state_q;
    logic [MID_W-1:0]         owner_q;
    logic [MID_W-1:0]         ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]      cnt_q, cnt_d;
    logic [MID_W-1:0]         win_idx;
    logic [WEIGHT_W-1:0]      win_weight, eff_weight;
    logic [WEIGHT_W:0]        cnt_inc;
    logic [NO_OF_MASTERS-1:0] pick_grant;

    apb_wrr_pick #(
        .N     (NO_OF_MASTERS),
        .MID_W (MID_W)
    ) u_pick (
        .req_i        (req_i),
        .ptr_i        (ptr_q),
        .fixed_prio_i (fixed_prio_i),
        .grant_o      (pick_grant)
    );

    // Weight is only looked at for the winner of the current grant cycle.
    always_comb begin
        win_idx    = '0;
        win_weight = '0;
        for (int m = 0; m < NO_OF_MASTERS; m++) begin
            if (pick_grant[m]) begin
                win_idx    = MID_W'(m);
                win_weight = weight_i[m*WEIGHT_W +: WEIGHT_W];
            end
        end
        eff_weight = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
        cnt_inc    = {1'b0, cnt_q} + (WEIGHT_W+1)'(1);
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        if (win_idx == ptr_q && cnt_inc < {1'b0, eff_weight}) begin
            cnt_d = cnt_inc[WEIGHT_W-1:0];
        end else begin
            ptr_d = (win_idx == MID_W'(NO_OF_MASTERS - 1)) ? '0 : win_idx + MID_W'(1);
            cnt_d = '0;
        end
    end

    assign grant_o = (state_q == IDLE) ? pick_grant : '0;
    assign owner_o = owner_q;
    assign busy_o  = (state_q == OWNED);

`ifdef APB_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_q;
    logic        timeout_q;

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
`ifdef APB_ARB_WATCHDOG_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef APB_ARB_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|pick_grant) begin
                        state_q <= OWNED;
                        owner_q <= win_idx;
`ifdef APB_ARB_WATCHDOG_EN
                        wd_q    <= '0;
`endif
                        if (!fixed_prio_i) begin
                            ptr_q <= ptr_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                OWNED: begin
                    if (done_i) begin
                        state_q <= IDLE;
`ifdef APB_ARB_WATCHDOG_EN
                    end else if (wd_q == WD_LAST) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 16'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wrr_arbiter.sv
// Self-checking bench for apb_wrr_arbiter: a 2-master and a 4-master instance,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_apb_wrr_arbiter;

    localparam int TMO = 8;
`ifdef APB_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        preset_n;
    logic [3:0]  req_s  [2];
    logic [15:0] w_s    [2];
    logic        fp_s   [2];
    logic        done_s [2];

    logic [1:0] grant2;
    logic [0:0] owner2;
    logic       busy2, tout2;
    logic [3:0] grant4;
    logic [1:0] owner4;
    logic       busy4, tout4;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state, index 0 = 2-master DUT, 1 = 4-master DUT.
    int nm [2] = '{2, 4};
    bit m_owned [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_ocyc  [2];
    bit m_tout  [2];

    always #5 clk = ~clk;

    apb_wrr_arbiter #(.NO_OF_MASTERS(2), .WEIGHT_W(4), .TIMEOUT_CYCLES(TMO)) u_dut2 (
        .pclk(clk), .preset_n(preset_n), .req_i(req_s[0][1:0]), .weight_i(w_s[0][7:0]),
        .fixed_prio_i(fp_s[0]), .done_i(done_s[0]), .grant_o(grant2), .owner_o(owner2),
        .busy_o(busy2), .timeout_o(tout2)
    );

    apb_wrr_arbiter #(.NO_OF_MASTERS(4), .WEIGHT_W(4), .TIMEOUT_CYCLES(TMO)) u_dut4 (
        .pclk(clk), .preset_n(preset_n), .req_i(req_s[1]), .weight_i(w_s[1]),
        .fixed_prio_i(fp_s[1]), .done_i(done_s[1]), .grant_o(grant4), .owner_o(owner4),
        .busy_o(busy4), .timeout_o(tout4)
    );

    function automatic logic [3:0] grant_of(input int d);
        return (d == 0) ? {2'b00, grant2} : grant4;
    endfunction
    function automatic int owner_of(input int d);
        return (d == 0) ? int'(owner2) : int'(owner4);
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? busy2 : busy4;
    endfunction
    function automatic logic tout_of(input int d);
        return (d == 0) ? tout2 : tout4;
    endfunction

    // Winner by the arbitration rules; -1 when nobody requests.
    function automatic int model_winner(input int d, input logic [3:0] req, input bit fp);
        int n = nm[d];
        for (int k = 0; k < n; k++) begin
            int i = fp ? k : (m_ptr[d] + k) % n;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input int d, input logic [3:0] req, input logic [15:0] w,
                              input bit fp, input bit done);
        int win, eff;
        m_tout[d] = 1'b0;
        if (!m_owned[d]) begin
            win = model_winner(d, req, fp);
            if (win >= 0) begin
                m_owned[d] = 1'b1;
                m_owner[d] = win;
                m_ocyc[d]  = 0;
                if (!fp) begin
                    eff = int'((w >> (4 * win)) & 16'hF);
                    if (eff == 0) eff = 1;
                    if (win == m_ptr[d] && m_cnt[d] + 1 < eff) m_cnt[d]++;
                    else begin
                        m_ptr[d] = (win + 1) % nm[d];
                        m_cnt[d] = 0;
                    end
                end
            end
        end else begin
            m_ocyc[d]++;
            if (done) m_owned[d] = 1'b0;
            else if (WD && m_ocyc[d] == TMO) begin
                m_owned[d] = 1'b0;
                m_tout[d]  = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        preset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = '0; w_s[d] = '0; fp_s[d] = 1'b0; done_s[d] = 1'b0;
            m_owned[d] = 1'b0; m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
            m_ocyc[d] = 0; m_tout[d] = 1'b0;
        end
        #2;
        preset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        req_s[0] = 4'b0010;
        req_s[1] = 4'b0100;
        #1;
        n_cmp++; if (busy2 !== 1'b0 || owner2 !== 1'b0 || tout2 !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs2: busy=%b owner=%b tout=%b expected 0 0 0", busy2, owner2, tout2); end
        n_cmp++; if (busy4 !== 1'b0 || owner4 !== 2'b00 || tout4 !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs4: busy=%b owner=%b tout=%b expected 0 00 0", busy4, owner4, tout4); end
        n_cmp++; if (grant2 !== 2'b10) begin
            n_bad++; $display("FAIL reset_grant2: got %b expected 10", grant2); end
        n_cmp++; if (grant4 !== 4'b0100) begin
            n_bad++; $display("FAIL reset_grant4: got %b expected 0100", grant4); end
        req_s[0] = '0;
        req_s[1] = '0;
        #1;
        preset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrr_weights();
        int exp_seq [6] = '{0, 0, 1, 0, 0, 1};
        apply_reset();
        req_s[0] = 4'b0011;
        w_s[0]   = 16'h0012;
        for (int g = 0; g < 6; g++) begin
            #1;
            n_cmp++; if (grant2 !== 2'(1 << exp_seq[g])) begin
                n_bad++; $display("FAIL wrr_grant[%0d]: got %b expected %b", g, grant2, 2'(1 << exp_seq[g])); end
            @(posedge clk); #1;
            n_cmp++; if (busy2 !== 1'b1 || int'(owner2) != exp_seq[g] || grant2 !== 2'b00) begin
                n_bad++; $display("FAIL wrr_owned[%0d]: busy=%b owner=%0d grant=%b expected 1 %0d 00",
                                  g, busy2, owner2, grant2, exp_seq[g]); end
            @(posedge clk); #1;
            done_s[0] = 1'b1;
            @(posedge clk); #1;
            done_s[0] = 1'b0;
        end
        req_s[0] = '0;
    endtask

    task automatic test_zero_weights();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_s[1] = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_cmp++; if (grant4 !== 4'(1 << exp_seq[g])) begin
                n_bad++; $display("FAIL zw_grant[%0d]: got %b expected %b", g, grant4, 4'(1 << exp_seq[g])); end
            @(posedge clk); #1;
            n_cmp++; if (busy4 !== 1'b1 || int'(owner4) != exp_seq[g]) begin
                n_bad++; $display("FAIL zw_owner[%0d]: busy=%b owner=%0d expected 1 %0d", g, busy4, owner4, exp_seq[g]); end
            done_s[1] = 1'b1;
            @(posedge clk); #1;
            done_s[1] = 1'b0;
        end
        req_s[1] = '0;
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        req_s[1] = 4'b1111;
        #1;
        n_cmp++; if (grant4 !== 4'b0001) begin
            n_bad++; $display("FAIL fp_pre_grant: got %b expected 0001", grant4); end
        @(posedge clk); #1;
        done_s[1] = 1'b1;
        @(posedge clk); #1;
        done_s[1] = 1'b0;
        fp_s[1]   = 1'b1;
        req_s[1]  = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            #1;
            n_cmp++; if (grant4 !== 4'b0010) begin
                n_bad++; $display("FAIL fp_grant[%0d]: got %b expected 0010", g, grant4); end
            @(posedge clk); #1;
            done_s[1] = 1'b1;
            @(posedge clk); #1;
            done_s[1] = 1'b0;
        end
        // Pointer must still be 1 from the round-robin grant before.
        fp_s[1]  = 1'b0;
        req_s[1] = 4'b1111;
        #1;
        n_cmp++; if (grant4 !== 4'b0010) begin
            n_bad++; $display("FAIL fp_ptr_hold: got %b expected 0010", grant4); end
        @(posedge clk); #1;
        req_s[1]  = '0;
        done_s[1] = 1'b1;
        @(posedge clk); #1;
        done_s[1] = 1'b0;
    endtask

    task automatic test_watchdog();
        apply_reset();
        req_s[0] = 4'b0001;
        #1;
        n_cmp++; if (grant2 !== 2'b01) begin
            n_bad++; $display("FAIL wd_grant: got %b expected 01", grant2); end
        @(posedge clk); #1;
        req_s[0] = '0;
`ifdef APB_ARB_WATCHDOG_EN
        for (int k = 1; k <= TMO; k++) begin
            n_cmp++; if (busy2 !== 1'b1 || tout2 !== 1'b0) begin
                n_bad++; $display("FAIL wd_owned[%0d]: busy=%b tout=%b expected 1 0", k, busy2, tout2); end
            @(posedge clk); #1;
        end
        n_cmp++; if (busy2 !== 1'b0 || tout2 !== 1'b1) begin
            n_bad++; $display("FAIL wd_expire: busy=%b tout=%b expected 0 1", busy2, tout2); end
        @(posedge clk); #1;
        n_cmp++; if (tout2 !== 1'b0) begin
            n_bad++; $display("FAIL wd_pulse_len: tout=%b expected 0", tout2); end
        req_s[0] = 4'b0001;
        @(posedge clk); #1;
        req_s[0] = '0;
        for (int k = 1; k <= TMO; k++) begin
            n_cmp++; if (busy2 !== 1'b1) begin
                n_bad++; $display("FAIL wd_done_owned[%0d]: busy=%b expected 1", k, busy2); end
            if (k == TMO) done_s[0] = 1'b1;
            @(posedge clk); #1;
        end
        done_s[0] = 1'b0;
        n_cmp++; if (busy2 !== 1'b0 || tout2 !== 1'b0) begin
            n_bad++; $display("FAIL wd_done_wins: busy=%b tout=%b expected 0 0", busy2, tout2); end
        @(posedge clk); #1;
        n_cmp++; if (tout2 !== 1'b0) begin
            n_bad++; $display("FAIL wd_done_nopulse: tout=%b expected 0", tout2); end
`else
        for (int k = 1; k <= 3 * TMO; k++) begin
            n_cmp++; if (busy2 !== 1'b1 || tout2 !== 1'b0) begin
                n_bad++; $display("FAIL nowd_owned[%0d]: busy=%b tout=%b expected 1 0", k, busy2, tout2); end
            @(posedge clk); #1;
        end
        done_s[0] = 1'b1;
        @(posedge clk); #1;
        done_s[0] = 1'b0;
        n_cmp++; if (busy2 !== 1'b0 || tout2 !== 1'b0) begin
            n_bad++; $display("FAIL nowd_release: busy=%b tout=%b expected 0 0", busy2, tout2); end
`endif
    endtask

    task automatic test_reset_mid_owned();
        apply_reset();
        req_s[0] = 4'b0010;
        @(posedge clk); #1;
        n_cmp++; if (busy2 !== 1'b1 || owner2 !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_owned: busy=%b owner=%b expected 1 1", busy2, owner2); end
        #2;
        preset_n = 1'b0;
        #1;
        n_cmp++; if (busy2 !== 1'b0 || owner2 !== 1'b0 || tout2 !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: busy=%b owner=%b tout=%b expected 0 0 0", busy2, owner2, tout2); end
        preset_n = 1'b1;
        #1;
        n_cmp++; if (grant2 !== 2'b10) begin
            n_bad++; $display("FAIL rst_regrant: got %b expected 10", grant2); end
        @(posedge clk); #1;
        n_cmp++; if (busy2 !== 1'b1 || owner2 !== 1'b1) begin
            n_bad++; $display("FAIL rst_reowned: busy=%b owner=%b expected 1 1", busy2, owner2); end
        req_s[0]  = '0;
        done_s[0] = 1'b1;
        @(posedge clk); #1;
        done_s[0] = 1'b0;
    endtask

    task automatic test_random(input int d, input int cycles);
        logic [3:0] exp_g;
        int         win;
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            req_s[d]  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) w_s[d] = 16'($urandom) & 16'h3333;
            fp_s[d]   = ($urandom_range(0, 3) == 0);
            done_s[d] = ($urandom_range(0, 2) == 0);
            #1;
            exp_g = '0;
            if (!m_owned[d]) begin
                win = model_winner(d, req_s[d], fp_s[d]);
                if (win >= 0) exp_g[win] = 1'b1;
            end
            n_cmp++; if (grant_of(d) !== exp_g) begin
                n_bad++; $display("FAIL rand_grant[n%0d c%0d]: got %b expected %b", nm[d], c, grant_of(d), exp_g); end
            @(posedge clk);
            model_edge(d, req_s[d], w_s[d], fp_s[d], done_s[d]);
            #1;
            n_cmp++; if (busy_of(d) !== m_owned[d] || tout_of(d) !== m_tout[d]) begin
                n_bad++; $display("FAIL rand_state[n%0d c%0d]: busy=%b tout=%b expected %b %b",
                                  nm[d], c, busy_of(d), tout_of(d), m_owned[d], m_tout[d]); end
            if (m_owned[d]) begin
                n_cmp++; if (owner_of(d) != m_owner[d]) begin
                    n_bad++; $display("FAIL rand_owner[n%0d c%0d]: got %0d expected %0d", nm[d], c, owner_of(d), m_owner[d]); end
            end
        end
        req_s[d] = '0; fp_s[d] = 1'b0; done_s[d] = 1'b0;
    endtask

    initial begin
        preset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = '0; w_s[d] = '0; fp_s[d] = 1'b0; done_s[d] = 1'b0;
        end
        #1;
        test_reset();
        test_wrr_weights();
        test_zero_weights();
        test_fixed_prio();
        test_watchdog();
        test_reset_mid_owned();
        test_random(0, 600);
        test_random(1, 600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_wrr_arbiter.md
APB_WRR_ARBITER -- requirements
Module: apb_wrr_arbiter

Interface
REQ-001 SHALL have parameter NO_OF_MASTERS, default 2, number of requesting APB masters (range 1..16).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-master weight field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, owned-cycle limit before forced release (range 2..65535).
REQ-004 SHALL have port pclk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port preset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_i  input  NO_OF_MASTERS  per-master SETUP-phase request (psel && !penable && address decoded to this slave).
REQ-007 SHALL have port weight_i  input  NO_OF_MASTERS*WEIGHT_W  packed weights; master m uses bits [m*WEIGHT_W +: WEIGHT_W].
REQ-008 SHALL have port fixed_prio_i  input  1  selects fixed priority (1) or weighted round-robin (0).
REQ-009 SHALL have port done_i  input  1  the owner's ACCESS cycle completes (psel && penable && pready).
REQ-010 SHALL have port grant_o  output  NO_OF_MASTERS  combinational one-hot grant.
REQ-011 SHALL have port owner_o  output  MID_W  registered index of the current owner; MID_W = max(1, clog2(NO_OF_MASTERS)).
REQ-012 SHALL have port busy_o  output  1  registered; 1 while a master owns the slave.
REQ-013 SHALL have port timeout_o  output  1  registered, one-cycle pulse on forced release; tied 0 when the watchdog is excluded.

Function
REQ-014 SHALL implement a two-state FSM, IDLE (busy_o=0) and OWNED (busy_o=1).
REQ-015 In IDLE, grant_o SHALL be one-hot when any req_i bit is set and zero when none is; in OWNED, grant_o SHALL be 0.
REQ-016 In IDLE, a non-zero grant SHALL move the FSM to OWNED on the next edge with owner_o set to the granted index (0 idle-to-grant latency, 1-cycle ownership latency).
REQ-017 In OWNED, done_i=1 SHALL move the FSM to IDLE on the next edge; no grant is issued in the done cycle, so the next owner's earliest grant cycle is done+1.
REQ-018 Weighted round-robin: search SHALL start at pointer ptr and wrap modulo NO_OF_MASTERS; the first set req_i bit wins.
REQ-019 On a WRR grant to master i: if i==ptr and cnt+1 < eff_weight(i), then cnt SHALL increment and ptr SHALL hold; otherwise ptr SHALL become (i+1) mod NO_OF_MASTERS and cnt SHALL become 0.
REQ-020 eff_weight SHALL equal weight_i field, with weight 0 treated as 1, sampled in the grant cycle only.
REQ-021 Fixed priority: the lowest set req_i index SHALL win; ptr and cnt SHALL hold.
REQ-022 Changing fixed_prio_i or weight_i while OWNED SHALL NOT affect the current owner.
REQ-023 For NO_OF_MASTERS=1: ptr SHALL stay 0 and grant_o SHALL equal req_i while IDLE.

Reset
REQ-024 preset_n low SHALL asynchronously force IDLE, busy_o=0, owner_o=0, ptr=0, cnt=0, timeout_o=0 and watchdog count=0; grant_o follows req_i in IDLE.
REQ-025 Reset asserted while OWNED SHALL drop ownership immediately, with no timeout_o pulse.

Configuration
REQ-026 With APB_ARB_WATCHDOG_EN defined: a counter SHALL clear on entry to OWNED and increment each OWNED cycle without done_i; when it reaches TIMEOUT_CYCLES-1 without done_i, the FSM SHALL go to IDLE and timeout_o SHALL pulse for 1 cycle; done_i in the same cycle takes precedence (no pulse).
REQ-027 Without APB_ARB_WATCHDOG_EN: no counter logic SHALL exist, timeout_o SHALL be constant 0, and OWNED exits only on done_i.

Structure
REQ-028 arb_state_e (IDLE/OWNED) and the MID_W helper SHALL reside in apb_global_pkg alongside NO_OF_MASTERS.
REQ-029 The selection logic SHALL be the sub-module apb_wrr_pick (combinational: req, ptr, fixed_prio -> one-hot winner), instanced once; the interconnect instantiates one apb_wrr_arbiter per slave.

Verification
REQ-030 N=2, weights {2,1}, req=2'b11 held, done_i every 2nd OWNED cycle -> grant sequence M0,M0,M1,M0,M0,M1.
REQ-031 N=4, weights all 0, req=4'b1111 -> grants 0,1,2,3,0 (weight 0 behaves as 1).
REQ-032 fixed_prio_i=1, req=4'b1010 -> grant_o=4'b0010 every arbitration; ptr remains unchanged afterwards.
REQ-033 Watchdog enabled, TIMEOUT_CYCLES=8, grant with no done_i -> busy_o falls after 8 OWNED cycles with a 1-cycle timeout_o pulse; done_i on cycle 8 -> no pulse.
REQ-034 preset_n low mid-OWNED -> busy_o=0 and owner_o=0 asynchronously; after reset release, req=2'b10 -> grant_o=2'b10 in the same cycle.
